// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   uart_state_e : frame-level state encoding
//   PAR_*        : parity-mode selectors for the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk     : system clock (rising edge)
//   rst_n   : asynchronous active-low reset, clears the counter
//   restart : reload CLKS_PER_BIT-1 (start of a new bit period)
//   tick    : counter is 0, i.e. this is the last cycle of the bit period
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Back-to-back frames are possible by offering the next
// byte during the final cycle of the last stop bit.
//   clk      : system clock (rising edge)
//   rst_n    : asynchronous active-low reset
//   tx_data  : byte to send, sampled on acceptance only
//   tx_valid : tx_data is valid
//   tx_ready : byte can be accepted this cycle
//   tx       : registered serial output, idle level 1
//   tx_busy  : high whenever not IDLE
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  import uart_pkg::*;

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        tx_q, tx_d;
  logic        ready_en_q, ready_en_d;
  logic        restart;
  logic        tick;
  logic        accept;
  logic        last_stop;
  logic        par_bit;
  logic [2:0]  next_idx;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  assign par_bit   = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);
  assign next_idx  = bit_idx_q + 3'd1;

  // ready_en_q keeps tx_ready low while in reset and rises on the first
  // clock after release, even though the state is already IDLE.
  assign tx_ready = ready_en_q &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_STOP) && tick && last_stop));
  assign accept   = tx_valid && tx_ready;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    ready_en_d = 1'b1;
    restart    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = ST_START;
          shift_d = tx_data;
          tx_d    = 1'b0;
          restart = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          restart   = 1'b1;
        end
      end

      ST_DATA: begin
        if (tick) begin
          restart = 1'b1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
          restart    = 1'b1;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (last_stop) begin
            stop_idx_d = 1'b0;
            if (accept) begin
              state_d = ST_START;
              shift_d = tx_data;
              tx_d    = 1'b0;
              restart = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
            restart    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule
